// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response plus the IR
// handoff to decode/control. The master side is the fetch unit.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] ir_out;
    logic [31:0] pc_out;
    logic        ir_valid;
    logic        ir_ready;

    modport master (
        output imem_req, imem_addr, ir_out, pc_out, ir_valid,
        input  imem_rdata, imem_valid, ir_ready
    );

    modport slave (
        input  imem_req, imem_addr, ir_out, pc_out, ir_valid,
        output imem_rdata, imem_valid, ir_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, one-entry IR buffer, redirect/halt handling.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    input  logic         halt,
    input  logic         resume,
    output logic         misalign_err,
    output logic [31:0]  fetch_cnt,
    output logic [31:0]  stall_cnt
);

    typedef enum logic [0:0] {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      state, state_next;
    logic [31:0] fetch_pc, fetch_pc_next;
    logic [31:0] ir_q, ir_next;
    logic [31:0] pc_q, pc_next;
    logic        ir_valid_q, ir_valid_next;
    logic        misalign_next;
    logic        req;
    logic        accept;

    // A request goes out only when the buffer is empty or drains this cycle.
    assign req    = !rst && (state == FETCH) && (!ir_valid_q || bus.ir_ready);
    assign accept = req && bus.imem_valid;

    assign bus.imem_req  = req;
    assign bus.imem_addr = fetch_pc;
    assign bus.ir_out    = ir_q;
    assign bus.pc_out    = pc_q;
    assign bus.ir_valid  = ir_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FETCH;
            fetch_pc     <= RESET_PC;
            ir_q         <= NOP;
            pc_q         <= RESET_PC;
            ir_valid_q   <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_next;
            fetch_pc     <= fetch_pc_next;
            ir_q         <= ir_next;
            pc_q         <= pc_next;
            ir_valid_q   <= ir_valid_next;
            misalign_err <= misalign_next;
        end
    end

    // Redirect beats halt beats accept/consume; any flush discards the response.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        ir_next       = ir_q;
        pc_next       = pc_q;
        ir_valid_next = ir_valid_q;
        misalign_next = misalign_err;
        case (state)
            FETCH: begin
                if (redirect_valid) begin
                    ir_valid_next = 1'b0;
                    if (redirect_pc[1:0] != 2'b00) begin
                        misalign_next = 1'b1;
                        state_next    = HALTED;
                    end else begin
                        fetch_pc_next = redirect_pc;
                    end
                end else if (halt) begin
                    state_next    = HALTED;
                    ir_valid_next = 1'b0;
                end else if (accept) begin
                    ir_next       = bus.imem_rdata;
                    pc_next       = fetch_pc;
                    ir_valid_next = 1'b1;
                    fetch_pc_next = fetch_pc + PC_INC;
                end else if (ir_valid_q && bus.ir_ready) begin
                    ir_valid_next = 1'b0;
                end
            end
            HALTED: begin
                ir_valid_next = 1'b0;
                if (resume && !misalign_err) begin
                    state_next = FETCH;
                end
            end
            default: begin
                state_next    = FETCH;
                ir_valid_next = 1'b0;
            end
        endcase
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;
    logic        accept_kept;
    logic        stalled;

    assign accept_kept = accept && (state == FETCH) && !redirect_valid && !halt;
    assign stalled     = (state == FETCH) && ir_valid_q && !bus.ir_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            if (accept_kept) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (stalled) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign fetch_cnt = 32'h0;
    assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-cycle vector table plus an IR
// scoreboard that tracks which fetched word should be sitting in the buffer.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        resume;
    logic        misalign_err;
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    fetch_unit_if ifc ();

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (ifc.master),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .resume         (resume),
        .misalign_err   (misalign_err),
        .fetch_cnt      (fetch_cnt),
        .stall_cnt      (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, rdy, vld, rv;
        logic [31:0] rpc;
        logic        hlt, res;
        logic        req;
        logic [31:0] addr;
        logic        irv;
        logic [31:0] pc;
        logic        mis;
        logic [31:0] fc, sc;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } sb_t;

    sb_t  sb[$];
    vec_t vecs[29];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'h8) return 32'h0050_0093;
        return {a[23:0], 8'h13};
    endfunction

    function automatic vec_t mk(input logic r, input logic rdy, input logic vld,
                                input logic rv, input logic [31:0] rpc,
                                input logic hlt, input logic res,
                                input logic req, input logic [31:0] addr,
                                input logic irv, input logic [31:0] pc,
                                input logic mis, input logic [31:0] fc,
                                input logic [31:0] sc);
        vec_t v;
        v.rst = r;   v.rdy = rdy; v.vld = vld; v.rv = rv; v.rpc = rpc;
        v.hlt = hlt; v.res = res; v.req = req; v.addr = addr; v.irv = irv;
        v.pc = pc;   v.mis = mis; v.fc = fc;   v.sc = sc;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst             = v.rst;
        ifc.ir_ready    = v.rdy;
        ifc.imem_valid  = v.vld;
        redirect_valid  = v.rv;
        redirect_pc     = v.rpc;
        halt            = v.hlt;
        resume          = v.res;
        ifc.imem_rdata  = memword(ifc.imem_addr);
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        logic [31:0] exp_fc;
        logic [31:0] exp_sc;
        sb_t         e;
`ifdef FETCH_PERF_CNT_EN
        exp_fc = v.fc;
        exp_sc = v.sc;
`else
        exp_fc = 32'h0;
        exp_sc = 32'h0;
`endif
        check32({tag, " imem_req"},     {31'd0, ifc.imem_req}, {31'd0, v.req});
        check32({tag, " imem_addr"},    ifc.imem_addr,         v.addr);
        check32({tag, " ir_valid"},     {31'd0, ifc.ir_valid}, {31'd0, v.irv});
        check32({tag, " pc_out"},       ifc.pc_out,            v.pc);
        check32({tag, " misalign_err"}, {31'd0, misalign_err}, {31'd0, v.mis});
        check32({tag, " fetch_cnt"},    fetch_cnt,             exp_fc);
        check32({tag, " stall_cnt"},    stall_cnt,             exp_sc);
        // The buffered word must match the oldest fetch still owed downstream.
        if (v.irv) begin
            if (sb.size() == 0) begin
                check32({tag, " sb_nonempty"}, 32'd0, 32'd1);
            end else begin
                e = sb[0];
                check32({tag, " sb_ir_out"}, ifc.ir_out, e.word);
                check32({tag, " sb_pc_out"}, ifc.pc_out, e.pc);
                if (v.rdy) void'(sb.pop_front());
            end
        end
        if (v.rst || v.rv || v.hlt) begin
            sb.delete();
        end else if (v.req && v.vld) begin
            e.pc   = v.addr;
            e.word = memword(v.addr);
            sb.push_back(e);
        end
    endtask

    task automatic runVector(input vec_t v, input string tag);
        applyStimulus(v);
        #1;
        checkOutput(v, tag);
        @(negedge clk);
    endtask

    initial begin
        //            rst rdy vld rv rpc          hlt res  req addr          irv pc           mis fc sc
        vecs[0]  = mk(0, 1, 1, 0, 32'h0,        0, 0,  1, 32'h0,        0, 32'h0,        0, 0, 0);
        vecs[1]  = mk(0, 1, 1, 0, 32'h0,        0, 0,  1, 32'h4,        1, 32'h0,        0, 1, 0);
        vecs[2]  = mk(0, 1, 1, 0, 32'h0,        0, 0,  1, 32'h8,        1, 32'h4,        0, 2, 0);
        vecs[3]  = mk(0, 0, 0, 0, 32'h0,        0, 0,  0, 32'hC,        1, 32'h8,        0, 3, 0);
        vecs[4]  = mk(0, 0, 0, 0, 32'h0,        0, 0,  0, 32'hC,        1, 32'h8,        0, 3, 1);
        vecs[5]  = mk(0, 0, 0, 0, 32'h0,        0, 0,  0, 32'hC,        1, 32'h8,        0, 3, 2);
        vecs[6]  = mk(0, 1, 1, 0, 32'h0,        0, 0,  1, 32'hC,        1, 32'h8,        0, 3, 3);
        vecs[7]  = mk(0, 1, 1, 1, 32'h200,      0, 0,  1, 32'h10,       1, 32'hC,        0, 4, 3);
        vecs[8]  = mk(0, 1, 1, 0, 32'h0,        0, 0,  1, 32'h200,      0, 32'hC,        0, 4, 3);
        vecs[9]  = mk(0, 1, 1, 1, 32'h40,       0, 0,  1, 32'h204,      1, 32'h200,      0, 5, 3);
        vecs[10] = mk(0, 1, 1, 0, 32'h0,        1, 0,  1, 32'h40,       0, 32'h200,      0, 5, 3);
        vecs[11] = mk(0, 1, 0, 1, 32'h300,      0, 0,  0, 32'h40,       0, 32'h200,      0, 5, 3);
        vecs[12] = mk(0, 1, 0, 0, 32'h0,        0, 0,  0, 32'h40,       0, 32'h200,      0, 5, 3);
        vecs[13] = mk(0, 1, 0, 0, 32'h0,        0, 1,  0, 32'h40,       0, 32'h200,      0, 5, 3);
        vecs[14] = mk(0, 1, 1, 0, 32'h0,        0, 0,  1, 32'h40,       0, 32'h200,      0, 5, 3);
        vecs[15] = mk(0, 1, 0, 0, 32'h0,        0, 0,  1, 32'h44,       1, 32'h40,       0, 6, 3);
        vecs[16] = mk(0, 1, 1, 1, 32'h202,      0, 0,  1, 32'h44,       0, 32'h40,       0, 6, 3);
        vecs[17] = mk(0, 1, 0, 0, 32'h0,        0, 1,  0, 32'h44,       0, 32'h40,       1, 6, 3);
        vecs[18] = mk(0, 1, 0, 0, 32'h0,        0, 0,  0, 32'h44,       0, 32'h40,       1, 6, 3);
        vecs[19] = mk(1, 1, 0, 0, 32'h0,        0, 0,  0, 32'h44,       0, 32'h40,       1, 6, 3);
        vecs[20] = mk(0, 1, 1, 0, 32'h0,        0, 0,  1, 32'h0,        0, 32'h0,        0, 0, 0);
        vecs[21] = mk(0, 1, 1, 0, 32'h0,        0, 0,  1, 32'h4,        1, 32'h0,        0, 1, 0);
        vecs[22] = mk(0, 1, 0, 0, 32'h0,        0, 0,  1, 32'h8,        1, 32'h4,        0, 2, 0);
        vecs[23] = mk(0, 1, 0, 0, 32'h0,        0, 0,  1, 32'h8,        0, 32'h4,        0, 2, 0);
        vecs[24] = mk(0, 1, 0, 0, 32'h0,        0, 0,  1, 32'h8,        0, 32'h4,        0, 2, 0);
        vecs[25] = mk(1, 1, 0, 0, 32'h0,        0, 0,  0, 32'h8,        0, 32'h4,        0, 2, 0);
        vecs[26] = mk(0, 0, 0, 0, 32'h0,        0, 0,  1, 32'h0,        0, 32'h0,        0, 0, 0);
        vecs[27] = mk(0, 0, 1, 0, 32'h0,        0, 0,  1, 32'h0,        0, 32'h0,        0, 0, 0);
        vecs[28] = mk(0, 0, 0, 0, 32'h0,        0, 0,  0, 32'h4,        1, 32'h0,        0, 1, 0);

        rst            = 1'b1;
        ifc.ir_ready   = 1'b0;
        ifc.imem_valid = 1'b0;
        ifc.imem_rdata = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;
        resume         = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        check32("reset ir_out",       ifc.ir_out,              32'h0000_0013);
        check32("reset pc_out",       ifc.pc_out,              32'h0);
        check32("reset ir_valid",     {31'd0, ifc.ir_valid},   32'd0);
        check32("reset imem_req",     {31'd0, ifc.imem_req},   32'd0);
        check32("reset imem_addr",    ifc.imem_addr,           32'h0);
        check32("reset misalign_err", {31'd0, misalign_err},   32'd0);
        check32("reset fetch_cnt",    fetch_cnt,               32'd0);
        check32("reset stall_cnt",    stall_cnt,               32'd0);

        for (int i = 0; i < 29; i++) begin
            runVector(vecs[i], $sformatf("vec%0d", i));
        end

        // Redirect to the top word, then check the PC wraps to zero.
        runVector(mk(0, 1, 0, 1, 32'hFFFF_FFFC, 0, 0, 1, 32'h4,        1, 32'h0,        0, 1, 1), "wrap0");
        runVector(mk(0, 1, 1, 0, 32'h0,         0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,        0, 1, 1), "wrap1");
        runVector(mk(0, 1, 0, 0, 32'h0,         0, 0, 1, 32'h0,        1, 32'hFFFF_FFFC, 0, 2, 1), "wrap2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
